// File: rtl/pwm_capture.sv
// pwm_capture: measures PWM high time and rise-to-rise period in clk cycles,
// flagging a stuck line with a saturating timeout report.
module pwm_capture #(
  parameter int W    = 9,
  parameter int SYNC = 2
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         pwm_in,
  output logic [W-1:0] duty,
  output logic [W-1:0] period,
  output logic         valid,
  output logic         overflow
);
  localparam logic [W-1:0] MAX = {W{1'b1}};
  localparam logic [W-1:0] ONE = W'(1);
  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;
  state_t          state, state_n;
  logic [SYNC-1:0] sync;
  logic            pwm_s, pwm_d, rise, at_max;
  logic [W-1:0]    per_cnt, high_cnt, per_n, high_n, duty_n, period_n;
  logic            valid_n, overflow_n;
  assign pwm_s  = sync[SYNC-1];
  assign rise   = pwm_s & ~pwm_d;
  assign at_max = per_cnt == MAX;
  always_ff @(posedge clk) begin
    if (!clr) begin
      state    <= IDLE;
      sync     <= '0;
      pwm_d    <= 1'b0;
      per_cnt  <= '0;
      high_cnt <= '0;
      duty     <= '0;
      period   <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      sync     <= {sync[SYNC-2:0], pwm_in};
      pwm_d    <= pwm_s;
      per_cnt  <= per_n;
      high_cnt <= high_n;
      duty     <= duty_n;
      period   <= period_n;
      valid    <= valid_n;
      overflow <= overflow_n;
    end
  end
  // A rise outranks the timeout, so a frame of exactly MAX cycles reports normally.
  always_comb begin
    state_n    = state;
    per_n      = per_cnt;
    high_n     = high_cnt;
    duty_n     = duty;
    period_n   = period;
    valid_n    = 1'b0;
    overflow_n = overflow;
    if (!en) begin
      state_n = IDLE;
      per_n   = '0;
      high_n  = '0;
    end else if (state == IDLE) begin
      state_n = ARM;
      per_n   = ONE;
      high_n  = '0;
    end else if (rise) begin
      state_n = MEAS;
      per_n   = ONE;
      high_n  = ONE;
      if (state == MEAS) begin
        period_n   = per_cnt;
        duty_n     = high_cnt;
        valid_n    = 1'b1;
        overflow_n = 1'b0;
      end
    end else if (at_max) begin
      state_n    = ARM;
      per_n      = ONE;
      high_n     = '0;
      period_n   = MAX;
      duty_n     = pwm_s ? MAX : '0;
      valid_n    = 1'b1;
      overflow_n = 1'b1;
    end else begin
      per_n  = per_cnt + ONE;
      high_n = (state == MEAS) ? high_cnt + W'(pwm_s) : '0;
    end
  end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: scoreboard bench; stimulus pushes expected reports, a monitor pops them on valid.
module tb_pwm_capture;
  typedef struct {
    logic [8:0] duty;
    logic [8:0] period;
    logic       ovf;
    int         gap;
  } exp_t;
  logic       clk = 1'b0, clr = 1'b0, en = 1'b0, pwm_in = 1'b0;
  logic [8:0] duty, period;
  logic       valid, overflow;
  exp_t       q[$];
  int         checks = 0, errors = 0, cyc = 0, last_cyc = 0;
  bit         have_prev = 0;
  int         prev_h, prev_p;
  logic [8:0] last_d = '0, last_p = '0;
  logic       last_o = 1'b0;
  int         hs[9] = '{1, 2, 3, 100, 127, 128, 200, 254, 255};

  pwm_capture #(.W(9), .SYNC(2)) dut (
    .clk(clk), .clr(clr), .en(en), .pwm_in(pwm_in),
    .duty(duty), .period(period), .valid(valid), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      exp_t e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got duty=%0d period=%0d overflow=%0b, required no report", duty, period, overflow);
      end else begin
        e = q.pop_front();
        if (duty !== e.duty || period !== e.period || overflow !== e.ovf) begin
          errors++;
          $display("FAIL report: got duty=%0d period=%0d overflow=%0b, required duty=%0d period=%0d overflow=%0b",
                   duty, period, overflow, e.duty, e.period, e.ovf);
        end
        if (e.gap != 0) begin
          checks++;
          if (cyc - last_cyc != e.gap) begin
            errors++;
            $display("FAIL report_gap: got %0d cycles, required %0d", cyc - last_cyc, e.gap);
          end
        end
      end
      last_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [8:0] act, logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push(int d, int p, bit o, int g);
    exp_t e;
    e.duty = 9'(d);
    e.period = 9'(p);
    e.ovf = o;
    e.gap = g;
    q.push_back(e);
    last_d = e.duty;
    last_p = e.period;
    last_o = o;
  endtask

  // act: 0 plain frame, 1 drop en for 10 cycles at cycle 100, 2 pulse clr at cycle 100
  task automatic frame(int p, int h, bit tmo, int act);
    if (have_prev) push(prev_h, prev_p, 1'b0, 0);
    if (tmo) push(0, 511, 1'b1, 0);
    for (int i = 0; i < p; i++) begin
      pwm_in = (i < h);
      if (act == 1 && i == 100) en = 1'b0;
      if (act == 1 && i == 110) begin
        chk("hold_duty", duty, last_d);
        chk("hold_period", period, last_p);
        chk("hold_overflow", {8'd0, overflow}, {8'd0, last_o});
        en = 1'b1;
      end
      if (act == 2 && i == 100) begin
        chk("pre_clr_overflow", {8'd0, overflow}, {8'd0, last_o});
        clr = 1'b0;
      end
      tick();
      if (act == 2 && i == 100) begin
        chk("clr_duty", duty, 9'd0);
        chk("clr_period", period, 9'd0);
        chk("clr_valid", {8'd0, valid}, 9'd0);
        chk("clr_overflow", {8'd0, overflow}, 9'd0);
        last_d = '0;
        last_p = '0;
        last_o = 1'b0;
        clr = 1'b1;
      end
    end
    prev_h = h;
    prev_p = p;
    have_prev = !tmo && act == 0;
  endtask

  task automatic stuck(bit v, int n, int len);
    have_prev = 0;
    for (int k = 0; k < n; k++) push(v ? 511 : 0, 511, 1'b1, k == 0 ? 0 : 511);
    pwm_in = v;
    repeat (len) tick();
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_duty", duty, 9'd0);
    chk("rst_period", period, 9'd0);
    chk("rst_valid", {8'd0, valid}, 9'd0);
    chk("rst_overflow", {8'd0, overflow}, 9'd0);
    clr = 1'b1;
    en = 1'b1;
    repeat (5) tick();
    repeat (4) frame(256, 64, 1'b0, 0);
    foreach (hs[i]) frame(256, hs[i], 1'b0, 0);
    stuck(1'b0, 2, 866);
    stuck(1'b1, 3, 1633);
    pwm_in = 1'b0;
    repeat (5) tick();
    frame(511, 100, 1'b0, 0);
    frame(511, 100, 1'b0, 0);
    frame(512, 100, 1'b1, 0);
    frame(256, 64, 1'b0, 2);
    frame(256, 64, 1'b0, 0);
    frame(256, 64, 1'b0, 0);
    frame(256, 64, 1'b0, 1);
    frame(256, 32, 1'b0, 0);
    frame(256, 32, 1'b0, 0);
    if (have_prev) push(prev_h, prev_p, 1'b0, 0);
    pwm_in = 1'b1;
    repeat (10) tick();
    for (int i = 0; i < 50 && q.size() != 0; i++) tick();
    chk("scoreboard_drained", 9'(q.size()), 9'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
